// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: start/result bus between a test controller and the exhaustive checker
interface truth_table_checker_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] stim;
    logic             resp;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [WIDTH-1:0] first_fail_vec;
    logic             first_fail_valid;
    modport master (
        output start, mode, resp,
        input  stim, busy, done, pass, mismatch_cnt, first_fail_vec, first_fail_valid
    );
    modport slave (
        input  start, mode, resp,
        output stim, busy, done, pass, mismatch_cnt, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/truth_table_checker.sv
// truth_table_checker: walks every input vector through a DUT and scores its response against a golden gate
module truth_table_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input logic                 clk,
    input logic                 rst,
    truth_table_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    state_t           state;
    logic [7:0]       settle_cnt;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] stim_q;
    logic [WIDTH-1:0] ffv_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             ffvalid_q;
    logic             exp_bit;
    // golden response for the vector currently applied, per the mode latched at start
    always_comb exp_bit = mode_q == 2'b00 ? ~&stim_q :
                          mode_q == 2'b01 ? ~|stim_q :
                          mode_q == 2'b10 ?  &stim_q : |stim_q;
    // run sequencer: apply vector, hold for the settle interval, score, advance or finish
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            mode_q     <= 2'b00;
            stim_q     <= '0;
            ffv_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ffvalid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state      <= APPLY;
                    settle_cnt <= '0;
                    mode_q     <= bus.mode;
                    stim_q     <= '0;
                    ffv_q      <= '0;
                    cnt_q      <= '0;
                    ffvalid_q  <= 1'b0;
                    busy_q     <= 1'b1;
                    done_q     <= 1'b0;
                end
                APPLY: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST) state <= CHECK;
                end
                CHECK: begin
                    if (bus.resp != exp_bit) begin
                        if (~&cnt_q) cnt_q <= cnt_q + CNT_W'(1);
                        if (!ffvalid_q) begin
                            ffv_q     <= stim_q;
                            ffvalid_q <= 1'b1;
                        end
                    end
                    if (&stim_q) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        stim_q     <= stim_q + WIDTH'(1);
                        settle_cnt <= '0;
                        state      <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.stim             = stim_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = done_q && cnt_q == '0;
    assign bus.mismatch_cnt     = cnt_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffvalid_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: scoreboard bench over three checker configurations
module tb_truth_table_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_checker_if #(.WIDTH(2), .CNT_W(8)) ia ();
    truth_table_checker_if #(.WIDTH(3), .CNT_W(2)) ib ();
    truth_table_checker_if #(.WIDTH(4), .CNT_W(8)) ic ();
    truth_table_checker #(.WIDTH(2), .SETTLE(1), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    truth_table_checker #(.WIDTH(3), .SETTLE(2), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    truth_table_checker #(.WIDTH(4), .SETTLE(3), .CNT_W(8)) dut_c (.clk(clk), .rst(rst), .bus(ic));

    typedef struct {
        logic [15:0] cnt;
        logic [15:0] ffv;
        logic        ffvv;
        logic        pass;
        int          lat;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   sq[$];
    int   sel_a = 0, sel_b = 0, sel_c = 0;
    int   st_a = 0, st_b = 0, st_c = 0;

    // modelled DUT: 0 = |~s (good NAND law), 1 = &~s, 2 = stuck 0, 3 = ~&~s (good OR law)
    function automatic logic model_resp(int sel, logic [15:0] s, int w);
        logic [15:0] m;
        logic [15:0] inv;
        m   = (16'd1 << w) - 16'd1;
        inv = ~s & m;
        case (sel)
            0:       return |inv;
            1:       return inv == m;
            2:       return 1'b0;
            default: return inv != m;
        endcase
    endfunction
    always_comb ia.resp = model_resp(sel_a, 16'(ia.stim), 2);
    always_comb ib.resp = model_resp(sel_b, 16'(ib.stim), 3);
    always_comb ic.resp = model_resp(sel_c, 16'(ic.stim), 4);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask
    task automatic fail(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not as required", name);
    endtask
    task automatic score(string tag, exp_t e, logic [15:0] cnt, logic [15:0] ffv, logic ffvv, logic pass, int lat);
        check({tag, ".mismatch_cnt"}, 32'(cnt), 32'(e.cnt));
        check({tag, ".first_fail_vec"}, 32'(ffv), 32'(e.ffv));
        check({tag, ".first_fail_valid"}, 32'(ffvv), 32'(e.ffvv));
        check({tag, ".pass"}, 32'(pass), 32'(e.pass));
        check({tag, ".latency"}, lat, e.lat);
    endtask

    logic       da_p = 1'b0, ba_p = 1'b0, db_p = 1'b0, dc_p = 1'b0;
    logic [1:0] sa_p = '0;
    always @(negedge clk) begin
        if (ia.done && !da_p) begin
            if (qa.size() == 0) fail("a.unexpected_done");
            else score("a", qa.pop_front(), 16'(ia.mismatch_cnt), 16'(ia.first_fail_vec),
                       ia.first_fail_valid, ia.pass, cyc - st_a - 1);
        end
        if (ia.busy && sq.size() > 0 && (!ba_p || ia.stim != sa_p))
            check("a.stim_step", 32'(ia.stim), sq.pop_front());
        da_p = ia.done;
        ba_p = ia.busy;
        sa_p = ia.stim;
    end
    always @(negedge clk) begin
        if (ib.done && !db_p) begin
            if (qb.size() == 0) fail("b.unexpected_done");
            else score("b", qb.pop_front(), 16'(ib.mismatch_cnt), 16'(ib.first_fail_vec),
                       ib.first_fail_valid, ib.pass, cyc - st_b - 1);
        end
        db_p = ib.done;
    end
    always @(negedge clk) begin
        if (ic.done && !dc_p) begin
            if (qc.size() == 0) fail("c.unexpected_done");
            else score("c", qc.pop_front(), 16'(ic.mismatch_cnt), 16'(ic.first_fail_vec),
                       ic.first_fail_valid, ic.pass, cyc - st_c - 1);
        end
        dc_p = ic.done;
    end

    task automatic push_steps();
        for (int i = 0; i < 4; i++) sq.push_back(i);
    endtask
    task automatic go_a(logic [1:0] m, int sel);
        @(negedge clk);
        sel_a = sel; ia.mode = m; ia.start = 1'b1; st_a = cyc;
        @(negedge clk);
        ia.start = 1'b0;
    endtask
    task automatic go_b(logic [1:0] m, int sel);
        @(negedge clk);
        sel_b = sel; ib.mode = m; ib.start = 1'b1; st_b = cyc;
        @(negedge clk);
        ib.start = 1'b0;
    endtask
    task automatic go_c(logic [1:0] m, int sel);
        @(negedge clk);
        sel_c = sel; ic.mode = m; ic.start = 1'b1; st_c = cyc;
        @(negedge clk);
        ic.start = 1'b0;
    endtask
    task automatic drain(string name, int budget);
        for (int i = 0; i < budget && qa.size() + qb.size() + qc.size() + sq.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (qa.size() + qb.size() + qc.size() + sq.size() > 0) begin
            fail({name, ".timeout"});
            qa.delete(); qb.delete(); qc.delete(); sq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
        ia.mode = 2'b00; ib.mode = 2'b00; ic.mode = 2'b00;
        repeat (3) @(negedge clk);
        check("rst.stim", 32'(ia.stim), 0);
        check("rst.busy", 32'(ia.busy), 0);
        check("rst.done", 32'(ia.done), 0);
        check("rst.pass", 32'(ia.pass), 0);
        check("rst.cnt", 32'(ia.mismatch_cnt), 0);
        check("rst.ffvv", 32'(ia.first_fail_valid), 0);
        check("rst.c_busy", 32'(ic.busy), 0);
        rst = 1'b0;
        // 1: correct NAND law
        qa.push_back('{16'd0, 16'd0, 1'b0, 1'b1, 8});
        push_steps();
        go_a(2'b00, 0);
        check("t1.busy", 32'(ia.busy), 1);
        drain("t1", 50);
        // 2: wrong law, vectors 1 and 2 fail
        qa.push_back('{16'd2, 16'd1, 1'b1, 1'b0, 8});
        push_steps();
        go_a(2'b00, 1);
        drain("t2", 50);
        // 3: stuck-at-0, counter saturates at 3
        qb.push_back('{16'd3, 16'd0, 1'b1, 1'b0, 24});
        go_b(2'b00, 2);
        drain("t3", 100);
        // 4: start and mode change mid-run are ignored
        qc.push_back('{16'd0, 16'd0, 1'b0, 1'b1, 64});
        go_c(2'b11, 3);
        repeat (8) @(negedge clk);
        ic.start = 1'b1; ic.mode = 2'b00;
        @(negedge clk);
        ic.start = 1'b0;
        check("t4.busy", 32'(ic.busy), 1);
        drain("t4", 200);
        // 5: reset mid-run aborts everything
        go_a(2'b00, 2);
        repeat (4) @(negedge clk);
        check("t5.pre_cnt", 32'(ia.mismatch_cnt), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5.stim", 32'(ia.stim), 0);
        check("t5.busy", 32'(ia.busy), 0);
        check("t5.done", 32'(ia.done), 0);
        check("t5.cnt", 32'(ia.mismatch_cnt), 0);
        check("t5.ffv", 32'(ia.first_fail_vec), 0);
        check("t5.ffvv", 32'(ia.first_fail_valid), 0);
        qa.push_back('{16'd0, 16'd0, 1'b0, 1'b1, 8});
        push_steps();
        go_a(2'b00, 0);
        drain("t5", 50);
        check("t6.done_held", 32'(ia.done), 1);
        // 6: restart from DONE with NOR golden
        qa.push_back('{16'd0, 16'd0, 1'b0, 1'b1, 8});
        push_steps();
        go_a(2'b01, 1);
        check("t6.done_drop", 32'(ia.done), 0);
        drain("t6", 50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Synthesizable, parametrised exhaustive checker for De Morgan-style combinational blocks.
- Drives every input vector (0 .. 2^WIDTH-1) onto the device under test, waits a settle interval, and samples the single-bit response.
- Compares each response against a built-in golden function and records the mismatch count and the first failing vector.
- Replaces free-running toggle stimulus with a self-checking, start/done-controlled sequence usable both on-board and in simulation.

Parameters:
WIDTH, 2, number of DUT inputs; legal range 1..16.
SETTLE, 1, cycles stim is held before the response is sampled; legal range 1..255.
CNT_W, 8, width of the saturating mismatch counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a run; accepted only in IDLE or DONE
mode  input  2  golden select, latched at start: 00 ~&stim, 01 ~|stim, 10 &stim, 11 |stim
stim  output  WIDTH  vector applied to the DUT
resp  input  1  DUT output, sampled in CHECK
busy  output  1  high in APPLY and CHECK
done  output  1  high in DONE; held until the next accepted start or reset
pass  output  1  done && mismatch_cnt==0
mismatch_cnt  output  CNT_W  number of failing vectors, saturating at 2^CNT_W-1
first_fail_vec  output  WIDTH  stim value of the first mismatch
first_fail_valid  output  1  high once first_fail_vec has been captured

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE, stim=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_vec=0, first_fail_valid=0, settle counter=0, latched mode=00. A reset mid-run aborts the run with no partial result kept.
- IDLE: start=1 -> APPLY. On that edge: stim=0, latch mode, clear mismatch_cnt and first_fail_*, settle counter=0.
- APPLY: stim held constant. Settle counter increments each cycle. Go to CHECK on the cycle the counter equals SETTLE-1, so APPLY lasts exactly SETTLE cycles per vector.
- CHECK (one cycle): compute exp from latched mode and current stim; mismatch = resp != exp.
  - On mismatch: mismatch_cnt increments unless already all ones (saturates, no wrap).
  - If first_fail_valid=0: first_fail_vec=stim and first_fail_valid=1. Later mismatches never overwrite it.
  - If stim == 2^WIDTH-1: go to DONE, leaving stim unchanged.
  - Otherwise: stim=stim+1, settle counter=0, go to APPLY.
- DONE: done=1, busy=0, pass combinational from done and count. start=1 restarts exactly as from IDLE, and done drops on the same edge.
- Start while busy is ignored, with no effect on stim, counters or mode.
- Changes on mode after start have no effect until the next accepted start.
- Latency: the first vector appears on stim one cycle after start is accepted. done rises exactly 2^WIDTH*(SETTLE+1) cycles after the start edge.
- resp is assumed stable by the end of the settle interval. No synchronizer is applied; an off-chip resp must be synchronized outside this block.

Test Plan:
1. WIDTH=2, SETTLE=1, mode=00, resp=|(~stim) (correct NAND De Morgan) -> stim steps 0,1,2,3; done rises 8 cycles after start; pass=1; mismatch_cnt=0; first_fail_valid=0.
2. Same setup, resp=&(~stim) (wrong law) -> mismatches at vectors 1 and 2; mismatch_cnt=2; first_fail_vec=2'b01; first_fail_valid=1; pass=0.
3. WIDTH=3, SETTLE=2, CNT_W=2, mode=00, resp stuck at 0 -> 7 failing vectors; mismatch_cnt saturates at 3; first_fail_vec=0; done 24 cycles after start.
4. WIDTH=4, SETTLE=3, mode=11, resp=~&(~stim); pulse start and change mode to 00 at cycle 10 -> start ignored, mode change ignored; done at cycle 64; pass=1.
5. Assert rst for one cycle in the middle of a WIDTH=2 run -> next cycle state is IDLE, stim=0, busy=0, done=0, counters=0; a fresh start completes normally.
6. After done, pulse start with mode=01 and resp=&(~stim) -> done drops on the start edge; the run repeats with cleared counters; pass=1 at the end.
